// File: rtl/nw_traceback_reader_if.sv
// Direction RAM read port plus the alignment-step stream of the
// Needleman-Wunsch traceback reader. The master side is the reader itself;
// the slave side is the RAM plus the downstream consumer of steps.
interface nw_traceback_reader_if #(
    parameter int W = 3
);
    // Direction RAM read port
    logic         en_traceB;
    logic [W-1:0] i_t;
    logic [W-1:0] j_t;
    logic [2:0]   symbol_out;

    // Alignment step stream (valid/ready)
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_op;
    logic [W-1:0] out_i;
    logic [W-1:0] out_j;
    logic         out_last;

    modport master (
        output en_traceB, i_t, j_t,
        input  symbol_out,
        output out_valid, out_op, out_i, out_j, out_last,
        input  out_ready
    );

    modport slave (
        input  en_traceB, i_t, j_t,
        output symbol_out,
        input  out_valid, out_op, out_i, out_j, out_last,
        output out_ready
    );
endinterface

// File: rtl/nw_traceback_reader.sv
// Needleman-Wunsch traceback reader: walks the score matrix from (N,N) back
// to (0,0), reading one Direction RAM symbol per interior cell, and streams
// the alignment steps last column first over a valid/ready handshake.
// Once a row or column reaches zero the remaining steps are pure gaps and
// are emitted one per cycle without touching the RAM.
// Optional build macro NW_TRACEBACK_STATS_EN adds per-op step counters
// (n_diag, n_gapA, n_gapB); without it those ports and counters are absent.
module nw_traceback_reader #(
    parameter int N = 5,
    parameter int W = $clog2(N + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    nw_traceback_reader_if.master        bus
`ifdef NW_TRACEBACK_STATS_EN
    ,
    output logic [$clog2(2*N+1)-1:0]     n_diag,
    output logic [$clog2(2*N+1)-1:0]     n_gapA,
    output logic [$clog2(2*N+1)-1:0]     n_gapB
`endif
);

    localparam logic [2:0] SYM_DIAG = 3'b100;
    localparam logic [2:0] SYM_UP   = 3'b010;
    localparam logic [2:0] SYM_LEFT = 3'b001;

    localparam logic [1:0] OP_DIAG  = 2'b00;
    localparam logic [1:0] OP_GAP_B = 2'b01;
    localparam logic [1:0] OP_GAP_A = 2'b10;

    localparam logic [W-1:0] ZERO = '0;
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] N_W  = W'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAP,
        S_EMIT,
        S_BORDER,
        S_DONE
    } state_t;

    state_t       state;
    logic [W-1:0] ri;
    logic [W-1:0] rj;
    logic [W-1:0] dec_i;
    logic [W-1:0] dec_j;

    // Only the three one-hot codes are meaningful direction symbols.
    function automatic logic sym_legal(input logic [2:0] s);
        return (s == SYM_DIAG) || (s == SYM_UP) || (s == SYM_LEFT);
    endfunction

    // UP consumes A[i] against a gap in B; LEFT consumes B[j] against a gap in A.
    function automatic logic [1:0] sym_to_op(input logic [2:0] s);
        case (s)
            SYM_UP:   return OP_GAP_B;
            SYM_LEFT: return OP_GAP_A;
            default:  return OP_DIAG;
        endcase
    endfunction

    // Coordinates after the currently presented step is accepted.
    always_comb begin
        dec_i = ri;
        dec_j = rj;
        case (bus.out_op)
            OP_DIAG: begin
                dec_i = ri - ONE;
                dec_j = rj - ONE;
            end
            OP_GAP_B: dec_i = ri - ONE;
            default:  dec_j = rj - ONE;
        endcase
    end

    // Walk controller; every output is a register so downstream sees clean levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            ri            <= ZERO;
            rj            <= ZERO;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            bus.en_traceB <= 1'b0;
            bus.i_t       <= ZERO;
            bus.j_t       <= ZERO;
            bus.out_valid <= 1'b0;
            bus.out_op    <= OP_DIAG;
            bus.out_i     <= ZERO;
            bus.out_j     <= ZERO;
            bus.out_last  <= 1'b0;
        end else begin
            done          <= 1'b0;
            bus.en_traceB <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ri            <= N_W;
                        rj            <= N_W;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        bus.en_traceB <= 1'b1;
                        bus.i_t       <= N_W - ONE;
                        bus.j_t       <= N_W - ONE;
                        state         <= S_READ;
                    end
                end
                S_READ: begin
                    // RAM data for the address issued here arrives next cycle.
                    state <= S_CAP;
                end
                S_CAP: begin
                    if (!sym_legal(bus.symbol_out)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        bus.out_op    <= sym_to_op(bus.symbol_out);
                        bus.out_i     <= ri;
                        bus.out_j     <= rj;
                        // Only a diagonal out of (1,1) lands on the origin from the interior.
                        bus.out_last  <= (bus.symbol_out == SYM_DIAG) && (ri == ONE) && (rj == ONE);
                        bus.out_valid <= 1'b1;
                        state         <= S_EMIT;
                    end
                end
                S_EMIT, S_BORDER: begin
                    if (bus.out_ready) begin
                        ri            <= dec_i;
                        rj            <= dec_j;
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if ((dec_i == ZERO) && (dec_j == ZERO)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else if ((dec_i == ZERO) || (dec_j == ZERO)) begin
                            // On an edge of the matrix the path is forced; no RAM needed.
                            bus.out_valid <= 1'b1;
                            bus.out_i     <= dec_i;
                            bus.out_j     <= dec_j;
                            bus.out_op    <= (dec_j == ZERO) ? OP_GAP_B : OP_GAP_A;
                            bus.out_last  <= ((dec_i == ONE) && (dec_j == ZERO)) ||
                                             ((dec_i == ZERO) && (dec_j == ONE));
                            state         <= S_BORDER;
                        end else begin
                            bus.en_traceB <= 1'b1;
                            bus.i_t       <= dec_i - ONE;
                            bus.j_t       <= dec_j - ONE;
                            state         <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NW_TRACEBACK_STATS_EN
    localparam int CW = $clog2(2*N+1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Per-op step counters, cleared by an accepted start and frozen between walks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_diag <= '0;
            n_gapA <= '0;
            n_gapB <= '0;
        end else if ((state == S_IDLE) && start) begin
            n_diag <= '0;
            n_gapA <= '0;
            n_gapB <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            case (bus.out_op)
                OP_DIAG:  n_diag <= n_diag + CNT_ONE;
                OP_GAP_B: n_gapB <= n_gapB + CNT_ONE;
                default:  n_gapA <= n_gapA + CNT_ONE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_nw_traceback_reader.sv
// Self-checking bench for nw_traceback_reader: a Direction RAM model, a
// path-walking reference of the expected steps/reads, directed scenarios
// and randomized RAM contents with random backpressure.
module tb_nw_traceback_reader;
    localparam int N = 5;
    localparam int W = $clog2(N + 1);
    localparam logic [2:0] S_DIAG = 3'b100;
    localparam logic [2:0] S_UP   = 3'b010;
    localparam logic [2:0] S_LEFT = 3'b001;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy, done, err;

    nw_traceback_reader_if #(.W(W)) bus ();

`ifdef NW_TRACEBACK_STATS_EN
    localparam int CW = $clog2(2*N+1);
    logic [CW-1:0] n_diag, n_gapA, n_gapB;
`endif

    nw_traceback_reader #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
`ifdef NW_TRACEBACK_STATS_EN
        ,
        .n_diag(n_diag),
        .n_gapA(n_gapA),
        .n_gapB(n_gapB)
`endif
    );

    always #5 clk = ~clk;

    // Direction RAM: synchronous read, data one cycle after the enable.
    logic [2:0] ram [N*N];
    always @(posedge clk) begin
        if (bus.en_traceB) begin
            if (int'(bus.i_t) < N && int'(bus.j_t) < N)
                bus.symbol_out <= ram[int'(bus.i_t) * N + int'(bus.j_t)];
            else
                bus.symbol_out <= 3'b000;
        end
    end

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] i;
        logic [W-1:0] j;
        logic         last;
    } step_t;

    step_t        expq[$];
    logic [W-1:0] rdi_q[$];
    logic [W-1:0] rdj_q[$];
    bit           exp_err;
    int           exp_nd, exp_na, exp_nb;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;
    int stall_left = 0;
    int n_xfer = 0;
    int cyc = 0;
    int last_rd_cyc = -1;
    int last_xfer_cyc = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fill_ram(input logic [2:0] v);
        for (int k = 0; k < N*N; k++) ram[k] = v;
    endtask

    // Reference: follow the path cell by cell from (N,N) to (0,0).
    task automatic build_model();
        int i, j, op, ni, nj;
        logic [2:0] s;
        step_t st;
        expq.delete(); rdi_q.delete(); rdj_q.delete();
        exp_err = 0; exp_nd = 0; exp_na = 0; exp_nb = 0;
        i = N; j = N;
        while (i > 0 || j > 0) begin
            if (i > 0 && j > 0) begin
                s = ram[(i-1)*N + (j-1)];
                rdi_q.push_back(W'(i-1));
                rdj_q.push_back(W'(j-1));
                if (s == S_DIAG)      op = 0;
                else if (s == S_UP)   op = 1;
                else if (s == S_LEFT) op = 2;
                else begin
                    exp_err = 1;
                    break;
                end
            end else begin
                op = (j == 0) ? 1 : 2;
            end
            ni = (op == 2) ? i : i - 1;
            nj = (op == 1) ? j : j - 1;
            st.op   = 2'(op);
            st.i    = W'(i);
            st.j    = W'(j);
            st.last = (ni == 0 && nj == 0);
            expq.push_back(st);
            if (op == 0) exp_nd++;
            else if (op == 1) exp_nb++;
            else exp_na++;
            i = ni; j = nj;
        end
    endtask

    // Advance one clock and update out_ready according to the current mode.
    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (n_xfer == 1 && bus.out_valid && stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
            default: bus.out_ready = 1'b0;
        endcase
    endtask

    // Start a walk and wait (bounded) for its done pulse; optionally pulse a
    // stray start while busy, which must be ignored.
    task automatic run_walk(input int mid_start);
        bit seen;
        seen = 0;
        n_xfer = 0;
        last_rd_cyc = -1;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("err_clear_on_start", err, 0);
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            start = (k == mid_start) && busy;
            @(negedge clk);
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("walk_done_seen", seen, 1);
    endtask

    // Compare process: checks reads, steps, handshake hold and done each cycle.
    initial begin
        bit    prev_hold, prev_done;
        step_t prev_pay, cur;
        prev_hold = 0;
        prev_done = 0;
        prev_pay  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_hold = 0;
                prev_done = 0;
            end else begin
                cur = {bus.out_op, bus.out_i, bus.out_j, bus.out_last};
                if (prev_hold) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_payload", cur, prev_pay);
                end
                if (bus.en_traceB) begin
                    chk("read_expected", int'(rdi_q.size() > 0), 1);
                    chk("read_while_busy", busy, 1);
                    if (rdi_q.size() > 0) begin
                        chk("read_i_t", bus.i_t, rdi_q[0]);
                        chk("read_j_t", bus.j_t, rdj_q[0]);
                        void'(rdi_q.pop_front());
                        void'(rdj_q.pop_front());
                    end
                    if (ready_mode == 0 && last_rd_cyc >= 0)
                        chk("read_spacing", cyc - last_rd_cyc, 3);
                    last_rd_cyc = cyc;
                end
                if (bus.out_valid) begin
                    chk("step_expected", int'(expq.size() > 0), 1);
                    chk("step_busy", busy, 1);
                    if (expq.size() > 0) begin
                        chk("step_op", bus.out_op, expq[0].op);
                        chk("step_i", bus.out_i, expq[0].i);
                        chk("step_j", bus.out_j, expq[0].j);
                        chk("step_last", bus.out_last, expq[0].last);
                    end
                    if (bus.out_ready) begin
                        if (expq.size() > 0) void'(expq.pop_front());
                        n_xfer++;
                        last_xfer_cyc = cyc;
                    end
                end
                if (done) begin
                    chk("done_single_cycle", prev_done, 0);
                    chk("done_steps_left", expq.size(), 0);
                    chk("done_reads_left", rdi_q.size(), 0);
                    chk("done_err", err, exp_err);
                    chk("done_busy_low", busy, 0);
                    if (!exp_err) chk("done_latency", cyc - last_xfer_cyc, 1);
`ifdef NW_TRACEBACK_STATS_EN
                    chk("stat_n_diag", n_diag, exp_nd);
                    chk("stat_n_gapA", n_gapA, exp_na);
                    chk("stat_n_gapB", n_gapB, exp_nb);
`endif
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_pay  = cur;
                prev_done = done;
            end
        end
    end

    // Stimulus
    initial begin
        bit reached;
        logic [2:0] v;
        bus.out_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en_traceB", bus.en_traceB, 0);
        chk("rst_i_t", bus.i_t, 0);
        chk("rst_j_t", bus.j_t, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_op", bus.out_op, 0);
        chk("rst_out_i", bus.out_i, 0);
        chk("rst_out_j", bus.out_j, 0);
        chk("rst_out_last", bus.out_last, 0);
        tick();
        rst = 1'b1;

        // All-DIAG matrix
        fill_ram(S_DIAG);
        build_model();
        chk("m1_steps", expq.size(), 5);
        chk("m1_reads", rdi_q.size(), 5);
        chk("m1_first_i", expq[0].i, 5);
        chk("m1_last_i", expq[4].i, 1);
        chk("m1_last_flag", expq[4].last, 1);
        chk("m1_ndiag", exp_nd, 5);
        ready_mode = 0;
        run_walk(-1);

        // One UP at RAM(4,4), path shifts right by one column
        fill_ram(S_DIAG);
        ram[4*N + 4] = S_UP;
        build_model();
        chk("m2_steps", expq.size(), 6);
        chk("m2_reads", rdi_q.size(), 5);
        chk("m2_first_op", expq[0].op, 1);
        chk("m2_tail_op", expq[5].op, 2);
        chk("m2_tail_j", expq[5].j, 1);
        run_walk(-1);

        // Last column all UP: five gaps down, then five border gaps left
        fill_ram(S_DIAG);
        for (int r = 0; r < N; r++) ram[r*N + 4] = S_UP;
        build_model();
        chk("m3_steps", expq.size(), 10);
        chk("m3_reads", rdi_q.size(), 5);
        chk("m3_border_i", expq[5].i, 0);
        chk("m3_border_j", expq[5].j, 5);
        run_walk(-1);

        // Backpressure: hold the second step for four cycles
        fill_ram(S_DIAG);
        build_model();
        ready_mode = 2;
        stall_left = 4;
        run_walk(-1);
        chk("stall_applied", stall_left, 0);
        ready_mode = 0;

        // Illegal symbol at RAM(3,3)
        fill_ram(S_DIAG);
        ram[3*N + 3] = 3'b011;
        build_model();
        chk("m5_err", exp_err, 1);
        chk("m5_steps", expq.size(), 1);
        chk("m5_reads", rdi_q.size(), 2);
        run_walk(-1);
        tick(); tick();
        @(negedge clk);
        chk("err_sticky", err, 1);
        fill_ram(S_DIAG);
        build_model();
        run_walk(-1);

        // Asynchronous reset while a step is presented
        fill_ram(S_DIAG);
        build_model();
        ready_mode = 3;
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        reached = 0;
        for (int k = 0; k < 20 && !reached; k++) begin
            @(negedge clk);
            if (bus.out_valid) reached = 1;
        end
        chk("reached_emit", reached, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_en_traceB", bus.en_traceB, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_op", bus.out_op, 0);
        chk("arst_out_i", bus.out_i, 0);
        chk("arst_out_j", bus.out_j, 0);
        chk("arst_out_last", bus.out_last, 0);
        chk("arst_i_t", bus.i_t, 0);
        chk("arst_j_t", bus.j_t, 0);
`ifdef NW_TRACEBACK_STATS_EN
        chk("arst_n_diag", n_diag, 0);
`endif
        expq.delete(); rdi_q.delete(); rdj_q.delete();
        ready_mode = 0;
        tick(); tick();
        rst = 1'b1;
        build_model();
        run_walk(-1);

        // Random matrices, random backpressure, stray starts while busy
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N*N; k++) begin
                if ($urandom_range(0, 39) == 0) begin
                    v = 3'($urandom_range(0, 7));
                    while (v == S_DIAG || v == S_UP || v == S_LEFT) v = 3'($urandom_range(0, 7));
                    ram[k] = v;
                end else begin
                    case ($urandom_range(0, 2))
                        0:       ram[k] = S_DIAG;
                        1:       ram[k] = S_UP;
                        default: ram[k] = S_LEFT;
                    endcase
                end
            end
            build_model();
            ready_mode = int'($urandom_range(0, 1));
            run_walk(int'($urandom_range(0, 12)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
